// File: rtl/board_checker.sv
// 3x3 board store and win/draw scanner for the game controller.
// Optional winning-line index output: define WIN_LINE_OUT_EN.
module board_checker #(
    parameter int ADDRW = 4,
    parameter int CELLW = 2
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             newGame,
    input  logic             boardWrite,
    input  logic [ADDRW-1:0] addr,
    input  logic [CELLW-1:0] cellState,
    input  logic [ADDRW-1:0] rdAddr,
    output logic [CELLW-1:0] rdCellState,
    output logic             busy,
    output logic             writeErr,
    output logic             gameIsDone,
    output logic [CELLW-1:0] winner
`ifdef WIN_LINE_OUT_EN
    ,
    output logic [2:0]       winLine
`endif
);

    localparam logic [CELLW-1:0] EMPTY  = CELLW'(2'b00);
    localparam logic [CELLW-1:0] MARK_X = CELLW'(2'b10);
    localparam logic [CELLW-1:0] MARK_O = CELLW'(2'b11);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_next;
    logic [CELLW-1:0] board [9];
    logic [2:0]       line_idx;
    logic             match_found;
    logic [CELLW-1:0] match_val;
    logic             write_err, err_next;
    logic             wr_accept;
    logic [3:0]       idx0, idx1, idx2;
    logic [CELLW-1:0] c0, c1, c2;
    logic             cur_match, found_now, board_full;
`ifdef WIN_LINE_OUT_EN
    logic [2:0]       match_line;
`endif

    // Cell indices of each win line, in scan order: rows, columns, diagonals.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_next = state;
        err_next   = 1'b0;
        wr_accept  = 1'b0;
        {idx0, idx1, idx2} = line_cells(line_idx);
        c0 = board[idx0];
        c1 = board[idx1];
        c2 = board[idx2];
        cur_match  = (c0 == c1) && (c1 == c2) && (c0 != EMPTY);
        found_now  = match_found || cur_match;
        board_full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board[i] == EMPTY) board_full = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (boardWrite) begin
                    if (addr < ADDRW'(9) && (cellState == MARK_X || cellState == MARK_O)
                        && board[addr] == EMPTY) begin
                        wr_accept  = 1'b1;
                        state_next = SCAN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                err_next = boardWrite;
                if (line_idx == 3'd7) begin
                    if (found_now || board_full) state_next = DONE;
                    else                         state_next = IDLE;
                end
            end
            DONE: err_next = boardWrite;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ph1) begin
        // NOTE: the board must clear on reset/newGame, so it is a reset register array rather than a RAM.
        if (!reset || newGame) begin
            state       <= IDLE;
            write_err   <= 1'b0;
            line_idx    <= '0;
            match_found <= 1'b0;
            match_val   <= EMPTY;
            for (int i = 0; i < 9; i++) board[i] <= EMPTY;
`ifdef WIN_LINE_OUT_EN
            match_line  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            state     <= state_next;
            write_err <= err_next;
            if (wr_accept) begin
                board[addr]  <= cellState;
                line_idx     <= '0;
                match_found  <= 1'b0;
                match_val    <= EMPTY;
`ifdef WIN_LINE_OUT_EN
                match_line   <= '0;
`endif
            end
            if (state == SCAN) begin
                line_idx <= line_idx + 3'd1;
                // Only the lowest-index matching line is kept.
                if (!match_found && cur_match) begin
                    match_found <= 1'b1;
                    match_val   <= c0;
`ifdef WIN_LINE_OUT_EN
                    match_line  <= line_idx;
`endif
                end
            end
        end
    end

    always_comb begin
        rdCellState = EMPTY;
        if (rdAddr < ADDRW'(9)) rdCellState = board[rdAddr];
    end

    assign busy       = (state == SCAN);
    assign writeErr   = write_err;
    assign gameIsDone = (state == DONE);
    assign winner     = gameIsDone ? match_val : EMPTY;
`ifdef WIN_LINE_OUT_EN
    assign winLine    = (gameIsDone && match_found) ? match_line : 3'b000;
`endif

endmodule

// File: tb/tb_board_checker.sv
// Self-checking bench for board_checker: directed scenarios plus random games
// compared against a line-table reference model.
module tb_board_checker;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] MX    = 2'b10;
    localparam logic [1:0] MO    = 2'b11;

    logic       ph1 = 1'b0;
    logic       reset = 1'b0;
    logic       newGame = 1'b0;
    logic       boardWrite = 1'b0;
    logic [3:0] addr = '0;
    logic [1:0] cellState = '0;
    logic [3:0] rdAddr = '0;
    logic [1:0] rdCellState;
    logic       busy, writeErr, gameIsDone;
    logic [1:0] winner;
`ifdef WIN_LINE_OUT_EN
    logic [2:0] winLine;
`endif

    board_checker dut (
        .ph1(ph1), .reset(reset), .newGame(newGame), .boardWrite(boardWrite),
        .addr(addr), .cellState(cellState), .rdAddr(rdAddr), .rdCellState(rdCellState),
        .busy(busy), .writeErr(writeErr), .gameIsDone(gameIsDone), .winner(winner)
`ifdef WIN_LINE_OUT_EN
        , .winLine(winLine)
`endif
    );

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: board contents and final game result.
    logic [1:0] mb [9];
    bit         mdone;
    logic [1:0] mwin;
    int         mline;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mb[i] = EMPTY;
        mdone = 0;
        mwin  = EMPTY;
        mline = 0;
    endtask

    task automatic model_eval(output bit done, output logic [1:0] w, output int ln);
        bit full;
        done = 0; w = EMPTY; ln = 0; full = 1;
        for (int l = 7; l >= 0; l--) begin
            if (mb[lines[l][0]] != EMPTY && mb[lines[l][0]] == mb[lines[l][1]]
                && mb[lines[l][1]] == mb[lines[l][2]]) begin
                done = 1; w = mb[lines[l][0]]; ln = l;
            end
        end
        for (int i = 0; i < 9; i++) if (mb[i] == EMPTY) full = 0;
        if (full) done = 1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, gameIsDone, mdone);
        check({tag, "_winner"}, winner, mdone ? mwin : EMPTY);
`ifdef WIN_LINE_OUT_EN
        check({tag, "_winline"}, winLine, (mdone && mwin != EMPTY) ? mline : 0);
`endif
    endtask

    task automatic check_board(input string tag);
        for (int i = 0; i < 11; i++) begin
            rdAddr = 4'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), rdCellState, (i < 9) ? mb[i] : EMPTY);
        end
    endtask

    task automatic new_game(input string tag);
        @(negedge ph1) newGame = 1'b1;
        @(negedge ph1) newGame = 1'b0;
        model_clear();
        check_status(tag);
        check_board(tag);
    endtask

    // Drive one write from IDLE or DONE and check the full response timeline.
    task automatic do_write(input string tag, input int a, input logic [1:0] v);
        bit         accept, d;
        logic [1:0] w;
        int         ln;
        accept = !mdone && a < 9 && (v == MX || v == MO) && (a < 9 && mb[a] == EMPTY);
        @(negedge ph1);
        boardWrite = 1'b1; addr = 4'(a); cellState = v; rdAddr = 4'(a);
        @(negedge ph1);
        boardWrite = 1'b0;
        if (accept) begin
            mb[a] = v;
            check({tag, "_err0"}, writeErr, 0);
            check({tag, "_rd"}, rdCellState, v);
            for (int k = 1; k < 8; k++) begin
                check($sformatf("%s_busy%0d", tag, k - 1), busy, 1);
                @(negedge ph1);
            end
            check({tag, "_busy7"}, busy, 1);
            @(negedge ph1);
            model_eval(d, w, ln);
            if (d) begin mdone = 1; mwin = w; mline = ln; end
            check_status({tag, "_end"});
        end else begin
            check({tag, "_err"}, writeErr, 1);
            check({tag, "_rdkeep"}, rdCellState, (a < 9) ? mb[a] : EMPTY);
            @(negedge ph1);
            check({tag, "_errpulse"}, writeErr, 0);
            check_status({tag, "_st"});
        end
    endtask

    initial begin
        model_clear();
        // 1: reset held low for two cycles
        reset = 1'b0;
        repeat (2) @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        check_status("t1");
        check("t1_err", writeErr, 0);
        check_board("t1");

        // 2: X takes the top row
        do_write("t2a", 0, MX);
        do_write("t2b", 3, MO);
        do_write("t2c", 1, MX);
        do_write("t2d", 4, MO);
        do_write("t2e", 2, MX);
        check("t2_done", gameIsDone, 1);
        check("t2_winner", winner, MX);
`ifdef WIN_LINE_OUT_EN
        check("t2_line", winLine, 0);
`endif
        do_write("t2_after", 8, MO);

        // 3: O wins on the anti-diagonal
        new_game("t3_ng");
        do_write("t3a", 2, MO);
        do_write("t3b", 0, MX);
        do_write("t3c", 4, MO);
        do_write("t3d", 5, MX);
        do_write("t3e", 6, MO);
        check("t3_winner", winner, MO);
`ifdef WIN_LINE_OUT_EN
        check("t3_line", winLine, 7);
`endif

        // 4: full board, no line
        new_game("t4_ng");
        do_write("t4a", 0, MX);
        do_write("t4b", 1, MO);
        do_write("t4c", 2, MX);
        do_write("t4d", 4, MO);
        do_write("t4e", 3, MX);
        do_write("t4f", 5, MO);
        do_write("t4g", 7, MX);
        do_write("t4h", 6, MO);
        do_write("t4i", 8, MX);
        check("t4_done", gameIsDone, 1);
        check("t4_winner", winner, EMPTY);

        // 5: rejected writes
        new_game("t5_ng");
        do_write("t5a", 4, MX);
        do_write("t5_occ", 4, MO);
        do_write("t5_addr9", 9, MX);
        do_write("t5_st01", 0, 2'b01);
        do_write("t5_st00", 0, EMPTY);
        // write during scan is dropped and scan latency is unchanged
        @(negedge ph1);
        boardWrite = 1'b1; addr = 4'd0; cellState = MX;
        @(negedge ph1);
        addr = 4'd1; cellState = MO;
        mb[0] = MX;
        check("t5_busy0", busy, 1);
        @(negedge ph1);
        boardWrite = 1'b0;
        check("t5_scanerr", writeErr, 1);
        check("t5_busy1", busy, 1);
        for (int k = 2; k < 8; k++) begin
            @(negedge ph1);
            check($sformatf("t5_busy%0d", k), busy, 1);
            check($sformatf("t5_noerr%0d", k), writeErr, 0);
        end
        @(negedge ph1);
        check_status("t5_end");
        check_board("t5");

        // 6: newGame aborts a scan
        new_game("t6_ng");
        @(negedge ph1);
        boardWrite = 1'b1; addr = 4'd0; cellState = MX;
        @(negedge ph1);
        boardWrite = 1'b0;
        check("t6_busy", busy, 1);
        repeat (3) @(negedge ph1);
        newGame = 1'b1;
        @(negedge ph1);
        newGame = 1'b0;
        model_clear();
        check_status("t6_abort");
        check_board("t6");
        do_write("t6_x4", 4, MX);
        check("t6_rd4", mb[4], MX);

        // newGame with a simultaneous write: clear wins, no error
        @(negedge ph1);
        newGame = 1'b1; boardWrite = 1'b1; addr = 4'd2; cellState = MO;
        @(negedge ph1);
        newGame = 1'b0; boardWrite = 1'b0;
        model_clear();
        check("t6_ngw_err", writeErr, 0);
        check_status("t6_ngw");
        check_board("t6_ngw");

        // random games
        for (int g = 0; g < 20; g++) begin
            new_game($sformatf("r%0d_ng", g));
            for (int n = 0; n < 30 && !mdone; n++) begin
                int a;
                logic [1:0] v;
                a = $urandom_range(0, 10);
                v = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3))
                                                : (($urandom_range(0, 1) == 1) ? MX : MO);
                do_write($sformatf("r%0d_w%0d", g, n), a, v);
            end
            do_write($sformatf("r%0d_post", g), $urandom_range(0, 8), MX);
            check_board($sformatf("r%0d", g));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
